// File: rtl/vec_arith_pkg.sv
// Shared sizing helpers for the vector arithmetic datapath.
// Both the accumulator ports and the adder tree derive their widths from these.
package vec_arith_pkg;

  function automatic int tree_levels(input int length);
    return $clog2(length);
  endfunction

  function automatic int sum_width(input int prd_width, input int length);
    return prd_width + $clog2(length);
  endfunction

endpackage

// File: rtl/add_tree_int.sv
// Pipelined signed adder tree: one register level per halving of the vector.
// Valid and last travel alongside the data and everything stalls on i_en=0.
module add_tree_int
  import vec_arith_pkg::*;
#(
  parameter int in_width = 16,
  parameter int length   = 32
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_en,
  input  logic                                          i_valid,
  input  logic                                          i_last,
  input  logic [length-1:0][in_width-1:0]               i_vec,
  output logic                                          o_valid,
  output logic                                          o_last,
  output logic signed [sum_width(in_width, length)-1:0] o_sum
);

  localparam int levels = tree_levels(length);
  localparam int leaves = 1 << levels;
  localparam int stages = (levels == 0) ? 1 : levels;
  localparam int sw     = sum_width(in_width, length);

  // lvl[0] is the zero-padded input vector, lvl[k] is the output of register stage k-1
  logic signed [sw-1:0] lvl  [stages][leaves];
  logic signed [sw-1:0] regs [stages][leaves];
  logic [stages-1:0]    vld;
  logic [stages-1:0]    lst;

  always_comb begin
    for (int k = 0; k < stages; k++)
      for (int j = 0; j < leaves; j++)
        lvl[k][j] = '0;
    for (int j = 0; j < length; j++)
      lvl[0][j] = sw'($signed(i_vec[j]));
    for (int k = 1; k < stages; k++)
      for (int j = 0; j < leaves; j++)
        lvl[k][j] = regs[k-1][j];
  end

  // A single-leaf tree degenerates to a plain pass-through register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < stages; k++)
        for (int j = 0; j < leaves; j++)
          regs[k][j] <= '0;
      vld <= '0;
      lst <= '0;
    end else if (i_en) begin
      for (int k = 0; k < stages; k++)
        for (int j = 0; j < leaves; j++) begin
          if (2*j + 1 < (leaves >> k))
            regs[k][j] <= lvl[k][(2*j) % leaves] + lvl[k][(2*j + 1) % leaves];
          else if (2*j < (leaves >> k))
            regs[k][j] <= lvl[k][(2*j) % leaves];
          else
            regs[k][j] <= '0;
        end
      vld[0] <= i_valid;
      lst[0] <= i_valid && i_last;
      for (int k = 1; k < stages; k++) begin
        vld[k] <= vld[k-1];
        lst[k] <= lst[k-1];
      end
    end
  end

  assign o_valid = vld[stages-1];
  assign o_last  = lst[stages-1];
  assign o_sum   = regs[stages-1][0];

endmodule

// File: rtl/vec_sum_acc_int.sv
// Reduces each product vector through the adder tree and accumulates beat sums per group,
// emitting one signed result per group over a valid/ready output.
module vec_sum_acc_int
  import vec_arith_pkg::*;
#(
  parameter int prd_width = 16,
  parameter int length    = 32,
  parameter int acc_width = sum_width(prd_width, length) + 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [length-1:0][prd_width-1:0] i_prd,
  input  logic                           i_valid,
  input  logic                           i_last,
  output logic                           o_ready,
  output logic signed [acc_width-1:0]    o_sum,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int tree_w = sum_width(prd_width, length);

  logic                        en;
  logic                        tree_valid;
  logic                        tree_last;
  logic signed [tree_w-1:0]    tree_sum;
  logic signed [acc_width-1:0] acc;
  logic signed [acc_width-1:0] next_sum;
  logic                        first;

  // One enable freezes the whole pipeline while a result waits on the consumer
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  add_tree_int #(
    .in_width (prd_width),
    .length   (length)
  ) u_tree (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (en),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_vec   (i_prd),
    .o_valid (tree_valid),
    .o_last  (tree_last),
    .o_sum   (tree_sum)
  );

  assign next_sum = (first ? '0 : acc) + acc_width'(tree_sum);

  // With en high, a pending result is either absent or being consumed this cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc     <= '0;
      first   <= 1'b1;
      o_sum   <= '0;
      o_valid <= 1'b0;
    end else if (en) begin
      o_valid <= 1'b0;
      if (tree_valid) begin
        if (tree_last) begin
          o_sum   <= next_sum;
          o_valid <= 1'b1;
          acc     <= '0;
          first   <= 1'b1;
        end else begin
          acc   <= next_sum;
          first <= 1'b0;
        end
      end
    end
  end

endmodule
